// File: rtl/instr_fetch_if.sv
// Instruction-memory fetch bus.
// master: fetch stage (drives imem_req/imem_addr, receives imem_ready/imem_rdata)
// slave : instruction memory
interface instr_fetch_if #(
    parameter int unsigned PC_W = 16
);
    logic            imem_req;
    logic [PC_W-1:0] imem_addr;
    logic            imem_ready;
    logic [15:0]     imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rdata
    );
endinterface

// File: rtl/instr_fetch.sv
// Instruction-fetch stage plus IF/ID pipeline register for the 16-bit core.
// Holds the PC, fetches over the imem interface, captures the instruction into
// IF/ID (with a one-entry skid buffer for ID stalls) and handles flush/branch.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   imem (master)              imem_req/imem_addr out, imem_ready/imem_rdata in
//   stall, flush               ID hold / squash IF/ID
//   branch_taken/target        PC redirect
//   id_valid, id_pc, id_pc_plus, id_opcode/one/two/three   IF/ID outputs
//   fetch_count, bubble_count  performance counters (only with FETCH_PERF_EN)
module instr_fetch #(
    parameter int unsigned     PC_W     = 16,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter int unsigned     PC_INC   = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    instr_fetch_if.master   imem,
    input  logic            stall,
    input  logic            flush,
    input  logic            branch_taken,
    input  logic [PC_W-1:0] branch_target,
    output logic            id_valid,
    output logic [PC_W-1:0] id_pc,
    output logic [PC_W-1:0] id_pc_plus,
    output logic [3:0]      id_opcode,
    output logic [3:0]      id_one,
    output logic [3:0]      id_two,
`ifdef FETCH_PERF_EN
    output logic [3:0]      id_three,
    output logic [15:0]     fetch_count,
    output logic [15:0]     bubble_count
`else
    output logic [3:0]      id_three
`endif
);
    localparam int unsigned INSTR_W = 16;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FETCH    = 2'd1,
        BUFFERED = 2'd2
    } state_t;

    state_t               state;
    logic [PC_W-1:0]      pc;
    logic [PC_W-1:0]      pc_next;
    logic [INSTR_W-1:0]   id_instr;
    logic [INSTR_W-1:0]   skid;

    assign pc_next = pc + PC_W'(PC_INC);

    // Request is live only while fetching; address always tracks the PC.
    assign imem.imem_req  = (state == FETCH);
    assign imem.imem_addr = pc;

    assign id_opcode = id_instr[15:12];
    assign id_one    = id_instr[11:8];
    assign id_two    = id_instr[7:4];
    assign id_three  = id_instr[3:0];

    // State, PC, skid buffer and IF/ID register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            pc         <= RESET_PC;
            skid       <= '0;
            id_valid   <= 1'b0;
            id_pc      <= '0;
            id_pc_plus <= '0;
            id_instr   <= '0;
`ifdef FETCH_PERF_EN
            fetch_count  <= '0;
            bubble_count <= '0;
`endif
        end else if (branch_taken) begin
            // Redirect drops any returning data and the buffered instruction.
            pc       <= branch_target;
            id_valid <= 1'b0;
            skid     <= '0;
            state    <= FETCH;
`ifdef FETCH_PERF_EN
            bubble_count <= bubble_count + 16'd1;
`endif
        end else if (flush) begin
            // PC untouched so the unconsumed instruction is fetched again.
            id_valid <= 1'b0;
            skid     <= '0;
            state    <= FETCH;
`ifdef FETCH_PERF_EN
            bubble_count <= bubble_count + 16'd1;
`endif
        end else begin
            case (state)
                IDLE: begin
                    state <= FETCH;
                end
                FETCH: begin
                    if (imem.imem_ready && !stall) begin
                        id_instr   <= imem.imem_rdata;
                        id_pc      <= pc;
                        id_pc_plus <= pc_next;
                        id_valid   <= 1'b1;
                        pc         <= pc_next;
`ifdef FETCH_PERF_EN
                        fetch_count <= fetch_count + 16'd1;
`endif
                    end else if (imem.imem_ready && stall) begin
                        skid  <= imem.imem_rdata;
                        state <= BUFFERED;
                    end else if (!stall) begin
                        id_valid <= 1'b0;
`ifdef FETCH_PERF_EN
                        bubble_count <= bubble_count + 16'd1;
`endif
                    end
                end
                BUFFERED: begin
                    if (!stall) begin
                        id_instr   <= skid;
                        id_pc      <= pc;
                        id_pc_plus <= pc_next;
                        id_valid   <= 1'b1;
                        pc         <= pc_next;
                        state      <= FETCH;
`ifdef FETCH_PERF_EN
                        fetch_count <= fetch_count + 16'd1;
`endif
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_instr_fetch.sv
// Directed self-checking bench for instr_fetch.
module tb_instr_fetch;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall, flush, branch_taken;
    logic [15:0] branch_target;
    logic        id_valid;
    logic [15:0] id_pc, id_pc_plus;
    logic [3:0]  id_opcode, id_one, id_two, id_three;
`ifdef FETCH_PERF_EN
    logic [15:0] fetch_count, bubble_count;
`endif

    // Second instance with a near-wrap reset PC.
    logic        w_valid;
    logic [15:0] w_pc, w_pc_plus;
    logic [3:0]  w_op, w_one, w_two, w_three;
`ifdef FETCH_PERF_EN
    logic [15:0] w_fc, w_bc;
`endif

    int pass_cnt = 0;
    int total    = 0;

    always #5 clk = ~clk;

    instr_fetch_if #(.PC_W(16)) bus ();
    instr_fetch_if #(.PC_W(16)) bus_w ();

    instr_fetch dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .imem          (bus.master),
        .stall         (stall),
        .flush         (flush),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .id_valid      (id_valid),
        .id_pc         (id_pc),
        .id_pc_plus    (id_pc_plus),
        .id_opcode     (id_opcode),
        .id_one        (id_one),
        .id_two        (id_two),
`ifdef FETCH_PERF_EN
        .id_three      (id_three),
        .fetch_count   (fetch_count),
        .bubble_count  (bubble_count)
`else
        .id_three      (id_three)
`endif
    );

    instr_fetch #(.RESET_PC(16'hFFFE)) dut_w (
        .clk           (clk),
        .rst_n         (rst_n),
        .imem          (bus_w.master),
        .stall         (1'b0),
        .flush         (1'b0),
        .branch_taken  (1'b0),
        .branch_target (16'h0000),
        .id_valid      (w_valid),
        .id_pc         (w_pc),
        .id_pc_plus    (w_pc_plus),
        .id_opcode     (w_op),
        .id_one        (w_one),
        .id_two        (w_two),
`ifdef FETCH_PERF_EN
        .id_three      (w_three),
        .fetch_count   (w_fc),
        .bubble_count  (w_bc)
`else
        .id_three      (w_three)
`endif
    );

    assign bus_w.imem_ready = 1'b1;
    assign bus_w.imem_rdata = 16'h0000;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Advance one edge; inputs change and outputs are sampled at the negedge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_fields(input string tag, input logic [15:0] instr, input logic [15:0] pc);
        chk({tag, ".valid"},  16'(id_valid), 16'd1);
        chk({tag, ".instr"},  {id_opcode, id_one, id_two, id_three}, instr);
        chk({tag, ".pc"},     id_pc, pc);
        chk({tag, ".pcplus"}, id_pc_plus, pc + 16'd2);
    endtask

    initial begin
        rst_n = 1'b0; stall = 1'b0; flush = 1'b0; branch_taken = 1'b0;
        branch_target = 16'h0000;
        bus.imem_ready = 1'b0; bus.imem_rdata = 16'h0000;
        @(negedge clk);
        @(negedge clk);
        chk("rst.valid", 16'(id_valid), 16'd0);
        chk("rst.req",   16'(bus.imem_req), 16'd0);
        chk("rst.addr",  bus.imem_addr, 16'h0000);
        chk("rst.pc",    id_pc, 16'h0000);
        chk("rst.pcplus", id_pc_plus, 16'h0000);
        chk("rst.instr", {id_opcode, id_one, id_two, id_three}, 16'h0000);
        chk("rst.waddr", bus_w.imem_addr, 16'hFFFE);

        // IDLE -> FETCH
        rst_n = 1'b1;
        step();
        chk("fetch.req",  16'(bus.imem_req), 16'd1);
        chk("fetch.addr", bus.imem_addr, 16'h0000);
        chk("wrap.addr0", bus_w.imem_addr, 16'hFFFE);

        // Streaming fetches
        bus.imem_ready = 1'b1; bus.imem_rdata = 16'h8123;
        step();
        chk_fields("s0", 16'h8123, 16'h0000);
        chk("s0.addr", bus.imem_addr, 16'h0002);
        chk("wrap.addr1", bus_w.imem_addr, 16'h0000);
        chk("wrap.pc",    w_pc, 16'hFFFE);
        chk("wrap.pcplus", w_pc_plus, 16'h0000);
        bus.imem_rdata = 16'h5123;
        step();
        chk_fields("s1", 16'h5123, 16'h0002);
        bus.imem_rdata = 16'hC123;
        step();
        chk_fields("s2", 16'hC123, 16'h0004);
        chk("s2.addr", bus.imem_addr, 16'h0006);

        // Two cycles of memory wait
        bus.imem_ready = 1'b0; bus.imem_rdata = 16'hDEAD;
        step();
        chk("wait0.valid", 16'(id_valid), 16'd0);
        chk("wait0.addr",  bus.imem_addr, 16'h0006);
        chk("wait0.hold",  {id_opcode, id_one, id_two, id_three}, 16'hC123);
        step();
        chk("wait1.valid", 16'(id_valid), 16'd0);
        chk("wait1.addr",  bus.imem_addr, 16'h0006);
        bus.imem_ready = 1'b1; bus.imem_rdata = 16'hA5B6;
        step();
        chk_fields("resume", 16'hA5B6, 16'h0006);

        // Stall three cycles with data returned on the first
        bus.imem_rdata = 16'h1234; stall = 1'b1;
        step();
        chk("stall0.req",  16'(bus.imem_req), 16'd0);
        chk_fields("stall0", 16'hA5B6, 16'h0006);
        bus.imem_ready = 1'b0; bus.imem_rdata = 16'hFFFF;
        step();
        chk("stall1.req",  16'(bus.imem_req), 16'd0);
        step();
        chk("stall2.req",  16'(bus.imem_req), 16'd0);
        chk("stall2.addr", bus.imem_addr, 16'h0008);
        stall = 1'b0;
        step();
        chk_fields("unstall", 16'h1234, 16'h0008);
        chk("unstall.req",  16'(bus.imem_req), 16'd1);
        chk("unstall.addr", bus.imem_addr, 16'h000A);

        // Branch with ready and stall in the same cycle
        bus.imem_ready = 1'b1; bus.imem_rdata = 16'h7777; stall = 1'b1;
        branch_taken = 1'b1; branch_target = 16'h0040;
        step();
        chk("br.valid", 16'(id_valid), 16'd0);
        chk("br.addr",  bus.imem_addr, 16'h0040);
        chk("br.req",   16'(bus.imem_req), 16'd1);
        branch_taken = 1'b0; stall = 1'b0; bus.imem_rdata = 16'h9ABC;
        step();
        chk_fields("br.tgt", 16'h9ABC, 16'h0040);

        // Flush refetches the same PC
        flush = 1'b1; bus.imem_rdata = 16'h1111;
        step();
        chk("fl.valid", 16'(id_valid), 16'd0);
        chk("fl.addr",  bus.imem_addr, 16'h0042);
        flush = 1'b0; bus.imem_rdata = 16'h2222;
        step();
        chk_fields("fl.refetch", 16'h2222, 16'h0042);
`ifdef FETCH_PERF_EN
        chk("perf.fetch",  fetch_count, 16'd7);
        chk("perf.bubble", bubble_count, 16'd4);
`endif

        // Reset while BUFFERED
        stall = 1'b1; bus.imem_rdata = 16'h3333;
        step();
        chk("buf.req", 16'(bus.imem_req), 16'd0);
        rst_n = 1'b0;
        #1;
        chk("mrst.valid", 16'(id_valid), 16'd0);
        chk("mrst.addr",  bus.imem_addr, 16'h0000);
        chk("mrst.req",   16'(bus.imem_req), 16'd0);
`ifdef FETCH_PERF_EN
        chk("mrst.fetch",  fetch_count, 16'd0);
        chk("mrst.bubble", bubble_count, 16'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1; stall = 1'b0; bus.imem_rdata = 16'h4444;
        step();
        chk("post.addr", bus.imem_addr, 16'h0000);
        step();
        chk_fields("post", 16'h4444, 16'h0000);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Instruction-fetch stage plus IF/ID pipeline register for the 16-bit core.
- Holds the PC, issues requests to instruction memory and captures the returned instruction.
- Splits the instruction into opcode, one, two and three fields, which feed the ID-stage sign-extend and register-read logic directly.
- Handles ID stalls, flushes and taken-branch redirects.

Parameters:
- PC_W, 16, PC and memory address width.
- RESET_PC, 16'h0000, PC value loaded at reset.
- PC_INC, 2, PC increment per delivered instruction (byte-addressed, 16-bit instructions).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- imem_req  output  1  fetch request valid.
- imem_addr  output  PC_W  fetch address; equals the current PC.
- imem_ready  input  1  imem_rdata is valid this cycle for imem_addr.
- imem_rdata  input  16  returned instruction.
- stall  input  1  ID cannot accept a new instruction; the IF/ID register holds.
- flush  input  1  squash the IF/ID contents.
- branch_taken  input  1  redirect the PC to branch_target.
- branch_target  input  PC_W  redirect address.
- id_valid  output  1  IF/ID register holds a live instruction.
- id_pc  output  PC_W  PC of the instruction in IF/ID.
- id_pc_plus  output  PC_W  id_pc + PC_INC.
- id_opcode  output  4  instr[15:12].
- id_one  output  4  instr[11:8].
- id_two  output  4  instr[7:4].
- id_three  output  4  instr[3:0].

Behaviour:
- Reset (async, rst_n=0):
  - pc=RESET_PC, state=IDLE, imem_req=0.
  - id_valid=0; id_pc, id_pc_plus and all field outputs = 0.
  - Skid buffer empty.
- Reset can assert at any time. It aborts any outstanding fetch, and imem_rdata arriving afterwards is ignored.
- IDLE: on the first clock after rst_n deasserts, go to FETCH.
- FETCH:
  - imem_req=1, imem_addr=pc (both driven combinationally from state and pc).
  - imem_ready=1 and stall=0: at the clock edge, load the fields from imem_rdata, id_pc=pc, id_pc_plus=pc+PC_INC, id_valid=1, pc+=PC_INC. Latency: address presented in cycle N with ready → ID outputs valid in cycle N+1.
  - imem_ready=1 and stall=1: store imem_rdata in the skid buffer, go to BUFFERED. The IF/ID register and pc hold.
  - imem_ready=0 and stall=0: id_valid<=0 (bubble); other ID outputs hold their values.
  - imem_ready=0 and stall=1: everything holds.
- BUFFERED:
  - imem_req=0.
  - While stall=1: hold.
  - When stall=0: load the IF/ID register from the buffer (id_pc=pc), pc+=PC_INC, go to FETCH.
- Redirect priority, highest first:
  1. rst_n
  2. branch_taken
  3. flush
  4. stall
  5. normal fetch
- branch_taken=1 (any state):
  - pc<=branch_target, id_valid<=0, skid buffer discarded, state<=FETCH.
  - Any imem_rdata returned that cycle is dropped.
  - Overrides stall.
- flush=1 without branch_taken:
  - id_valid<=0, skid buffer discarded, state<=FETCH.
  - pc unchanged, so the unconsumed instruction is refetched.
  - Overrides stall.
- pc arithmetic is modulo 2^PC_W: 16'hFFFE + 2 wraps to 16'h0000 with no flag.
- When id_valid drops, the field outputs are not cleared; consumers qualify them with id_valid.
- At most one instruction is ever buffered, so no overflow condition exists.

Optional Feature:
- Macro: FETCH_PERF_EN.
- When defined:
  - Adds output fetch_count [15:0]: increments on every IF/ID load with id_valid<=1 (direct or from the buffer).
  - Adds output bubble_count [15:0]: increments on every cycle that id_valid<=0 is loaded due to imem_ready=0 or a redirect.
  - Both counters are reset to 0 by rst_n and wrap at 16'hFFFF→0.
- When undefined: both ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset then imem_ready tied 1 with rdata 16'h8123, 16'h5123, 16'hC123 → id_opcode 8/5/C in successive cycles; id_one=1, id_two=2, id_three=3; id_pc 0,2,4; id_pc_plus 2,4,6.
- imem_ready=0 for 2 cycles mid-stream → id_valid=0 for 2 cycles; pc holds; resumes at the same address.
- stall=1 for 3 cycles while ready=1 returns 16'h1234 → ID holds the previous instruction, imem_req=0 in BUFFERED; on release id_opcode=1, id_one=2, id_two=3, id_three=4, no instruction lost.
- branch_taken=1, branch_target=16'h0040 in the same cycle as ready=1 and stall=1 → id_valid=0 next cycle, imem_addr=16'h0040, buffer discarded.
- RESET_PC=16'hFFFE → second fetch address is 16'h0000.
- rst_n pulsed low mid-BUFFERED → immediate id_valid=0, pc=RESET_PC, imem_req=0; with FETCH_PERF_EN defined, fetch_count and bubble_count=0.
